// File: rtl/run_length_serializer.sv
// Run-length serializer: turns (bit, length) commands into a single-bit stream w
// and carries a reference model of an N-identical-samples detector (z_exp).
// Optional macro RLS_PRBS_IDLE_EN: idle fill from a 7-bit LFSR instead of IDLE_BIT.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_bit/cmd_len are sampled only then, and a stalled offer must be held stable.
module run_length_serializer #(
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned RUN_THRESH = 4,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic [3:0]       run_cnt,
    output logic             z_exp,
    output logic             dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] THRESH = 4'(RUN_THRESH);

    state_t           r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_bit;
    logic             r_w_valid;
    logic             r_busy;
    logic             r_ready;
    logic             r_last_w;
    logic [3:0]       r_run;
    logic             w_accept;
    logic             w_load;
    logic             w_stream;

    assign w_accept = cmd_valid && r_ready;
    assign w_load   = w_accept && (cmd_len != '0);

    // A zero-length command is consumed like any other but never loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_bit     <= IDLE_BIT;
            r_w_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state   <= S_SHIFT;
                        r_rem     <= cmd_len;
                        r_bit     <= cmd_bit;
                        r_w_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_ready   <= (cmd_len == LEN_W'(1));
                    end
                end
                S_SHIFT: begin
                    if (r_rem != LEN_W'(1)) begin
                        r_rem   <= r_rem - LEN_W'(1);
                        r_ready <= (r_rem == LEN_W'(2));
                    end else if (w_load) begin
                        r_rem   <= cmd_len;
                        r_bit   <= cmd_bit;
                        r_ready <= (cmd_len == LEN_W'(1));
                    end else begin
                        r_state   <= S_IDLE;
                        r_rem     <= '0;
                        r_bit     <= IDLE_BIT;
                        r_w_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RLS_PRBS_IDLE_EN
    logic [6:0] r_lfsr;

    // x^7 + x^6 + 1; only steps while idle so the fill sequence resumes after a command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 7'h7F;
        end else if (r_state == S_IDLE) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end

    assign w_stream = r_busy ? r_bit : r_lfsr[0];
`else
    assign w_stream = r_bit;
`endif

    // Reference detector samples the emitted stream, idle fill included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run    <= 4'd0;
            r_last_w <= IDLE_BIT;
        end else begin
            if ((r_run != 4'd0) && (w_stream == r_last_w)) begin
                r_run <= (r_run >= THRESH) ? THRESH : r_run + 4'd1;
            end else begin
                r_run <= 4'd1;
            end
            r_last_w <= w_stream;
        end
    end

    assign cmd_ready = r_ready;
    assign w         = w_stream;
    assign w_valid   = r_w_valid;
    assign busy      = r_busy;
    assign run_cnt   = r_run;
    assign z_exp     = (r_run == THRESH);
    assign dbg_state = (r_state == S_SHIFT);

endmodule

// File: tb/tb_run_length_serializer.sv
// Self-checking bench for run_length_serializer: per-cycle expected bit queue
// plus an independent run-length / z_exp model, checked on the falling edge.
module tb_run_length_serializer;

    localparam int LEN_W = 4;
    localparam int TH    = 4;
`ifdef RLS_PRBS_IDLE_EN
    localparam bit PRBS = 1'b1;
`else
    localparam bit PRBS = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_bit   = 1'b0;
    logic [LEN_W-1:0] cmd_len   = '0;
    logic             cmd_ready;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic [3:0]       run_cnt;
    logic             z_exp;
    logic             dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic       exp_q[$];
    logic       m_valid = 1'b0;
    logic       m_w     = 1'b0;
    logic       m_last  = 1'b0;
    logic       m_ready = 1'b1;
    logic [3:0] m_run   = 4'd0;
    logic [6:0] m_lfsr  = 7'h7F;

    run_length_serializer #(
        .LEN_W      (LEN_W),
        .RUN_THRESH (TH),
        .IDLE_BIT   (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_bit   (cmd_bit),
        .cmd_len   (cmd_len),
        .w         (w),
        .w_valid   (w_valid),
        .busy      (busy),
        .run_cnt   (run_cnt),
        .z_exp     (z_exp),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model state advance on each rising edge; reset clears it asynchronously.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_q.delete();
                m_run   = 4'd0;
                m_last  = 1'b0;
                m_valid = 1'b0;
                m_ready = 1'b1;
                m_lfsr  = 7'h7F;
                m_w     = PRBS ? 1'b1 : 1'b0;
            end else begin
                if (m_run != 4'd0 && m_w == m_last)
                    m_run = (m_run >= 4'(TH)) ? 4'(TH) : m_run + 4'd1;
                else
                    m_run = 4'd1;
                m_last = m_w;
                if (!m_valid)
                    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
                if (cmd_valid && m_ready)
                    for (int i = 0; i < int'(cmd_len); i++)
                        exp_q.push_back(cmd_bit);
            end
        end
    end

    // Scoreboard: pop this cycle's expected bit and compare every output.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (exp_q.size() != 0) begin
                    m_valid = 1'b1;
                    m_w     = exp_q.pop_front();
                end else begin
                    m_valid = 1'b0;
                    m_w     = PRBS ? m_lfsr[0] : 1'b0;
                end
                m_ready = (exp_q.size() == 0);
                check("w",         32'(w),         32'(m_w));
                check("w_valid",   32'(w_valid),   32'(m_valid));
                check("busy",      32'(busy),      32'(m_valid));
                check("dbg_state", 32'(dbg_state), 32'(m_valid));
                check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
                check("run_cnt",   32'(run_cnt),   32'(m_run));
                check("z_exp",     32'(z_exp),     32'(m_run == 4'(TH)));
            end
        end
    end

    task automatic send(input logic b, input logic [LEN_W-1:0] l);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_bit   = b;
        cmd_len   = l;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(posedge clk);
            acc = m_ready;
        end
        check("cmd_accepted", 32'(acc), 32'd1);
        #1;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        idle(6);

        send(1'b1, 4'd4);
        idle(7);

        send(1'b1, 4'd2);
        send(1'b1, 4'd2);
        idle(6);

        send(1'b1, 4'd3);
        send(1'b0, 4'd3);
        idle(6);

        send(1'b1, 4'd0);
        idle(3);
        send(1'b1, 4'd15);
        idle(6);

        send(1'b1, 4'd10);
        idle(1);
        #2 reset = 1'b1;
        #1;
        check("rst_w",         32'(w),         32'(PRBS ? 1'b1 : 1'b0));
        check("rst_w_valid",   32'(w_valid),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_run_cnt",   32'(run_cnt),   32'd0);
        check("rst_z_exp",     32'(z_exp),     32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        idle(20);

        for (int k = 0; k < 24; k++) begin
            send(1'($urandom_range(0, 1)), LEN_W'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 5));
        end
        idle(20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
